// File: rtl/nios_display_pio_pkg.sv
// Shared constants for the Nios display input PIO.
//   ADDR_*  : Avalon word addresses of the four registers
//   EDGE_*  : encodings of the EDGE_MODE parameter
package nios_display_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_RAW  = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: SYNC_STAGES-deep synchroniser followed by a debounce filter.
// The filtered value only follows the synchronised value after it has differed
// for DEBOUNCE_CYCLES consecutive cycles.
//   clk, reset : system clock, synchronous active-high reset
//   din        : asynchronous input pin
//   sync       : synchronised (unfiltered) value
//   filt       : debounced value
module pio_debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic filt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic [CNT_W-1:0]       cnt;

  assign sync = sync_pipe[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_pipe <= '0;
      cnt       <= '0;
      filt      <= 1'b0;
    end else begin
      // synchroniser stage boundary
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], din};
      // debounce stage boundary: any agreement restarts the run length
      if (sync == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        filt <= sync;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/nios_display_pio_in_edge.sv
// Avalon-MM input PIO with per-bit synchronise/debounce, sticky edge capture
// (write-1-to-clear), per-bit interrupt mask and a level interrupt.
//   clk, reset        : system clock, synchronous active-high reset
//   address/chipselect/write_n/writedata : Avalon slave write/addr inputs
//   readdata          : registered read data, one-cycle latency
//   in_port           : asynchronous switch/button inputs
//   irq               : |(edge_capture & irq_mask)
// Register map: 0 filt (RO), 1 irq_mask (RW), 2 edge_capture (R/W1C), 3 sync (RO)
module nios_display_pio_in_edge
  import nios_display_pio_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_MODE       = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] filt_d;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rd_mux;
  logic             wr;
  logic             unused_writedata;

  // Upper write-data bits beyond WIDTH carry no meaning.
  assign unused_writedata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .din  (in_port[i]),
      .sync (sync[i]),
      .filt (filt[i])
    );
  end

  assign wr  = chipselect & ~write_n;
  assign clr = (wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
  assign irq = |(edge_capture & irq_mask);

  always_comb begin
    edge_hit = filt & ~filt_d;
    case (EDGE_MODE)
      EDGE_FALL: edge_hit = ~filt & filt_d;
      EDGE_ANY:  edge_hit = filt ^ filt_d;
      default:   edge_hit = filt & ~filt_d;
    endcase
  end

  always_comb begin
    rd_mux = filt;
    case (address)
      ADDR_DATA: rd_mux = filt;
      ADDR_MASK: rd_mux = irq_mask;
      ADDR_EDGE: rd_mux = edge_capture;
      ADDR_RAW:  rd_mux = sync;
      default:   rd_mux = filt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_d       <= '0;
      edge_capture <= '0;
      irq_mask     <= '0;
      readdata     <= '0;
    end else begin
      // edge stage boundary: a new edge beats a simultaneous clear
      filt_d       <= filt;
      edge_capture <= edge_hit | (edge_capture & ~clr);
      if (wr && address == ADDR_MASK) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      // read stage boundary
      readdata <= 32'(rd_mux);
    end
  end

endmodule
